// File: rtl/alu_seq_unit.sv
// Registered RV32I ALU with an iterative RV32M multiply/divide engine behind a start/valid handshake.
// Latency 1 cycle for simple/illegal ops and WIDTH+1 for MUL/DIV; start is ignored while ready is low.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ALU_opc,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef enum logic [1:0] {K_SIMPLE, K_MUL, K_DIV} kind_t;

    function automatic logic [WIDTH-1:0] base_op(input logic [2:0] f3, input logic alt,
                                                 input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [SHW-1:0]          sh;
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        logic [WIDTH-1:0]        sra;
        sh  = y[SHW-1:0];
        sx  = x;
        sy  = y;
        sra = sx >>> sh;
        case (f3)
            3'd0:    base_op = alt ? x - y : x + y;
            3'd1:    base_op = x << sh;
            3'd2:    base_op = {{(WIDTH-1){1'b0}}, sx < sy};
            3'd3:    base_op = {{(WIDTH-1){1'b0}}, x < y};
            3'd4:    base_op = x ^ y;
            3'd5:    base_op = alt ? sra : x >> sh;
            3'd6:    base_op = x | y;
            default: base_op = x & y;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [SHW:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               neg_q, neg_d;
    logic               hi_q, hi_d;
    logic               rem_q, rem_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ill_q, ill_d;

    kind_t              kind;
    logic               dec_ill;
    logic [WIDTH-1:0]   simple_res;
    logic               a_sgn, b_sgn;

    always_comb begin
        kind       = K_SIMPLE;
        dec_ill    = 1'b0;
        simple_res = '0;
        a_sgn      = 1'b0;
        b_sgn      = 1'b0;
        case (ALU_opc)
            2'b00: simple_res = a + b;
            2'b01: simple_res = a - b;
            2'b10: begin
                case (func7)
                    7'h00: simple_res = base_op(func3, 1'b0, a, b);
                    7'h20: begin
                        if (func3 == 3'd0 || func3 == 3'd5) simple_res = base_op(func3, 1'b1, a, b);
                        else dec_ill = 1'b1;
                    end
                    7'h01: begin
                        // Low-half MUL is sign-agnostic, so it runs unsigned.
                        if (func3[2]) begin
                            kind  = K_DIV;
                            a_sgn = ~func3[0];
                            b_sgn = ~func3[0];
                        end else begin
                            kind  = K_MUL;
                            a_sgn = (func3 == 3'd1) || (func3 == 3'd2);
                            b_sgn = (func3 == 3'd1);
                        end
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                if (func3 == 3'd1 && func7 != 7'h00) dec_ill = 1'b1;
                else if (func3 == 3'd5 && func7 != 7'h00 && func7 != 7'h20) dec_ill = 1'b1;
                else simple_res = base_op(func3, (func3 == 3'd5) && (func7 == 7'h20), a, b);
            end
        endcase
    end

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = a_sgn & a[WIDTH-1];
    assign b_neg = b_sgn & b[WIDTH-1];
    assign a_mag = a_neg ? '0 - a : a;
    assign b_mag = b_neg ? '0 - b : b;

    // Multiply: low half holds the remaining multiplier bits, high half accumulates.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt, mul_fix;
    logic [WIDTH-1:0]   mul_out;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_fix = neg_q ? '0 - mul_nxt : mul_nxt;
    assign mul_out = hi_q ? mul_fix[2*WIDTH-1:WIDTH] : mul_fix[WIDTH-1:0];

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    logic [WIDTH:0]     r_sh, r_diff;
    logic               r_ge;
    logic [WIDTH-1:0]   r_new, div_raw, div_out;
    logic [2*WIDTH-1:0] div_nxt;
    assign r_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign r_ge    = r_sh >= {1'b0, opd_q};
    assign r_diff  = r_sh - {1'b0, opd_q};
    assign r_new   = r_ge ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign div_nxt = {r_new, acc_q[WIDTH-2:0], r_ge};
    assign div_raw = rem_q ? r_new : div_nxt[WIDTH-1:0];
    assign div_out = neg_q ? '0 - div_raw : div_raw;

    logic last_iter;
    assign last_iter = (cnt_q == {{SHW{1'b0}}, 1'b1});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        rem_d   = rem_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (kind)
                        K_MUL: begin
                            state_d = S_MUL;
                            cnt_d   = (SHW+1)'(WIDTH);
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            opd_d   = a_mag;
                            neg_d   = a_neg ^ b_neg;
                            hi_d    = (func3 != 3'd0);
                        end
                        K_DIV: begin
                            state_d = S_DIV;
                            cnt_d   = (SHW+1)'(WIDTH);
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            opd_d   = b_mag;
                            rem_d   = func3[1];
                            // Divide-by-zero keeps the all-ones quotient unsigned.
                            neg_d   = func3[1] ? a_neg : (a_neg ^ b_neg) & (|b);
                        end
                        default: begin
                            state_d = S_DONE;
                            res_d   = simple_res;
                            zero_d  = (simple_res == '0);
                            ill_d   = dec_ill;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q - 1'b1;
                if (last_iter) begin
                    state_d = S_DONE;
                    res_d   = mul_out;
                    zero_d  = (mul_out == '0);
                    ill_d   = 1'b0;
                end
            end
            S_DIV: begin
                acc_d = div_nxt;
                cnt_d = cnt_q - 1'b1;
                if (last_iter) begin
                    state_d = S_DONE;
                    res_d   = div_out;
                    zero_d  = (div_out == '0);
                    ill_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            rem_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = ~ready;
    assign valid   = (state_q == S_DONE);
    assign result  = res_q;
    assign zero    = zero_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed vectors, randomized ops against an arithmetic reference model,
// reset abort and an 8-bit instance.
module tb_alu_seq_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start;
    logic [1:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, result;
    logic        ready, busy, valid, zero, illegal;

    logic        start8;
    logic [1:0]  opc8;
    logic [2:0]  f3_8;
    logic [6:0]  f7_8;
    logic [7:0]  a8, b8, result8;
    logic        ready8, busy8, valid8, zero8, illegal8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    alu_seq_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ALU_opc(opc), .func3(f3), .func7(f7),
        .a(a), .b(b), .ready(ready), .busy(busy), .valid(valid),
        .result(result), .zero(zero), .illegal(illegal)
    );

    alu_seq_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .ALU_opc(opc8), .func3(f3_8), .func7(f7_8),
        .a(a8), .b(b8), .ready(ready8), .busy(busy8), .valid(valid8),
        .result(result8), .zero(zero8), .illegal(illegal8)
    );

    typedef struct {
        logic [1:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        int          lat;
    } vec_t;

    // Reference: RISC-V semantics via 64-bit arithmetic.
    function automatic void model(input logic [1:0] o, input logic [2:0] g3, input logic [6:0] g7,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic il, output int lat);
        longint sx, sy, ux, uy, p;
        int     sh;
        bit     alt;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'h0, x};
        uy = {32'h0, y};
        sh = int'(y[4:0]);
        r = 32'h0; il = 1'b0; lat = 1; alt = 1'b0;
        case (o)
            2'd0: r = x + y;
            2'd1: r = x - y;
            default: begin
                if (o == 2'd2 && g7 == 7'h01) begin
                    lat = 33;
                    case (g3)
                        3'd0: begin p = sx * sy; r = p[31:0]; end
                        3'd1: begin p = sx * sy; r = p[63:32]; end
                        3'd2: begin p = sx * uy; r = p[63:32]; end
                        3'd3: begin p = ux * uy; r = p[63:32]; end
                        3'd4: if (y == 0) r = 32'hFFFFFFFF; else begin p = sx / sy; r = p[31:0]; end
                        3'd5: if (y == 0) r = 32'hFFFFFFFF; else begin p = ux / uy; r = p[31:0]; end
                        3'd6: if (y == 0) r = x; else begin p = sx % sy; r = p[31:0]; end
                        default: if (y == 0) r = x; else begin p = ux % uy; r = p[31:0]; end
                    endcase
                end else begin
                    if (o == 2'd2) begin
                        il  = !(g7 == 7'h00 || (g7 == 7'h20 && (g3 == 3'd0 || g3 == 3'd5)));
                        alt = (g7 == 7'h20);
                    end else begin
                        il  = (g3 == 3'd1 && g7 != 7'h00) || (g3 == 3'd5 && g7 != 7'h00 && g7 != 7'h20);
                        alt = (g3 == 3'd5 && g7 == 7'h20);
                    end
                    if (!il) begin
                        case (g3)
                            3'd0: r = alt ? x - y : x + y;
                            3'd1: r = x << sh;
                            3'd2: r = (sx < sy) ? 32'd1 : 32'd0;
                            3'd3: r = (ux < uy) ? 32'd1 : 32'd0;
                            3'd4: r = x ^ y;
                            3'd5: begin p = alt ? (sx >>> sh) : (ux >> sh); r = p[31:0]; end
                            3'd6: r = x | y;
                            default: r = x & y;
                        endcase
                    end
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 9);
            default: return $urandom;
        endcase
    endfunction

    // Issues one op on the 32-bit DUT, scrambles inputs after acceptance, waits (bounded) for valid.
    task automatic do_op(input logic [1:0] o, input logic [2:0] g3, input logic [6:0] g7,
                         input logic [31:0] x, input logic [31:0] y, input bit noise,
                         output logic [31:0] r, output logic z, output logic il,
                         output int lat, output bit hs_ok);
        hs_ok = 1'b1;
        @(negedge clk);
        if (ready !== 1'b1) hs_ok = 1'b0;
        opc = o; f3 = g3; f7 = g7; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; f3 = 3'($urandom); f7 = 7'($urandom); opc = 2'($urandom);
        lat = 1;
        while (valid !== 1'b1 && lat < 100) begin
            if (ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
        r = result; z = zero; il = illegal;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (zero !== 1'b1)    begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
        checks++;
        if (ready8 !== 1'b1 || valid8 !== 1'b0 || result8 !== 8'h0 || zero8 !== 1'b1) begin
            errors++; $display("FAIL reset_w8 got rdy=%b vld=%b res=%h z=%b exp 1 0 00 1", ready8, valid8, result8, zero8);
        end
        rst = 1'b1;
    endtask

    task automatic test_alu;
        vec_t v[8];
        logic [31:0] r; logic z, il; int lat; bit ok;
        v[0] = '{2'd0, 3'd0, 7'h00, 32'd5,        32'd7,        32'd12,       1'b0, 1};
        v[1] = '{2'd1, 3'd0, 7'h00, 32'd9,        32'd9,        32'd0,        1'b0, 1};
        v[2] = '{2'd2, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1};
        v[3] = '{2'd2, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1};
        v[4] = '{2'd2, 3'd2, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1};
        v[5] = '{2'd3, 3'd1, 7'h20, 32'h55,       32'd1,        32'd0,        1'b1, 1};
        v[6] = '{2'd3, 3'd5, 7'h20, 32'hF0000000, 32'd4,        32'hFF000000, 1'b0, 1};
        v[7] = '{2'd2, 3'd0, 7'h7F, 32'd1,        32'd2,        32'd0,        1'b1, 1};
        foreach (v[i]) begin
            do_op(v[i].opc, v[i].f3, v[i].f7, v[i].a, v[i].b, 1'b0, r, z, il, lat, ok);
            checks++; if (r !== v[i].exp) begin errors++; $display("FAIL alu[%0d]_result got %h exp %h", i, r, v[i].exp); end
            checks++; if (z !== (v[i].exp == 32'h0)) begin errors++; $display("FAIL alu[%0d]_zero got %b exp %b", i, z, v[i].exp == 32'h0); end
            checks++; if (il !== v[i].ill) begin errors++; $display("FAIL alu[%0d]_illegal got %b exp %b", i, il, v[i].ill); end
            checks++; if (lat != v[i].lat) begin errors++; $display("FAIL alu[%0d]_latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++; if (!ok) begin errors++; $display("FAIL alu[%0d]_handshake got bad ready/busy exp ok", i); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r, x, y; logic z, il; int lat, prev; bit ok;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            x = $urandom; y = $urandom;
            do_op(2'd0, 3'd0, 7'h00, x, y, 1'b0, r, z, il, lat, ok);
            checks++; if (r !== x + y) begin errors++; $display("FAIL b2b[%0d]_result got %h exp %h", i, r, x + y); end
            if (i > 0) begin
                checks++; if (cyc - prev != 2) begin errors++; $display("FAIL b2b[%0d]_spacing got %0d exp 2", i, cyc - prev); end
            end
            prev = cyc;
            @(posedge clk); #1;
            checks++; if (valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d]_pulse got vld=%b rdy=%b exp 0 1", i, valid, ready); end
        end
    endtask

    task automatic test_mul;
        vec_t v[4];
        logic [31:0] r; logic z, il; int lat, seen; bit ok;
        v[0] = '{2'd2, 3'd0, 7'h01, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0, 33};
        v[1] = '{2'd2, 3'd1, 7'h01, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 1'b0, 33};
        v[2] = '{2'd2, 3'd3, 7'h01, 32'hFFFFFFFF, 32'd3, 32'h00000002, 1'b0, 33};
        v[3] = '{2'd2, 3'd2, 7'h01, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFF, 1'b0, 33};
        foreach (v[i]) begin
            do_op(v[i].opc, v[i].f3, v[i].f7, v[i].a, v[i].b, 1'b1, r, z, il, lat, ok);
            checks++; if (r !== v[i].exp) begin errors++; $display("FAIL mul[%0d]_result got %h exp %h", i, r, v[i].exp); end
            checks++; if (z !== (v[i].exp == 32'h0) || il !== v[i].ill) begin errors++; $display("FAIL mul[%0d]_flags got z=%b il=%b exp %b %b", i, z, il, v[i].exp == 32'h0, v[i].ill); end
            checks++; if (lat != v[i].lat) begin errors++; $display("FAIL mul[%0d]_latency got %0d exp %0d", i, lat, v[i].lat); end
            checks++; if (!ok) begin errors++; $display("FAIL mul[%0d]_handshake got bad ready/busy exp ok", i); end
        end
        seen = 0;
        repeat (40) begin @(negedge clk); if (valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL mul_no_extra_valid got %0d exp 0", seen); end
    endtask

    task automatic test_div;
        vec_t v[8];
        logic [31:0] r; logic z, il; int lat; bit ok;
        v[0] = '{2'd2, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33};
        v[1] = '{2'd2, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
        v[2] = '{2'd2, 3'd5, 7'h01, 32'd100,      32'd7,        32'd14,       1'b0, 33};
        v[3] = '{2'd2, 3'd7, 7'h01, 32'd100,      32'd7,        32'd2,        1'b0, 33};
        v[4] = '{2'd2, 3'd5, 7'h01, 32'h1234,     32'd0,        32'hFFFFFFFF, 1'b0, 33};
        v[5] = '{2'd2, 3'd6, 7'h01, 32'h1234,     32'd0,        32'h1234,     1'b0, 33};
        v[6] = '{2'd2, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
        v[7] = '{2'd2, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
        foreach (v[i]) begin
            do_op(v[i].opc, v[i].f3, v[i].f7, v[i].a, v[i].b, 1'b1, r, z, il, lat, ok);
            checks++; if (r !== v[i].exp) begin errors++; $display("FAIL div[%0d]_result got %h exp %h", i, r, v[i].exp); end
            checks++; if (z !== (v[i].exp == 32'h0) || il !== v[i].ill) begin errors++; $display("FAIL div[%0d]_flags got z=%b il=%b exp %b %b", i, z, il, v[i].exp == 32'h0, v[i].ill); end
            checks++; if (lat != v[i].lat) begin errors++; $display("FAIL div[%0d]_latency got %0d exp %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_random;
        logic [31:0] r, x, y, er; logic z, il, eil; int lat, elat, k; bit ok;
        logic [1:0] o; logic [2:0] g3; logic [6:0] g7;
        for (int n = 0; n < 150; n++) begin
            o  = 2'($urandom);
            g3 = 3'($urandom);
            k  = $urandom_range(0, 7);
            g7 = (k < 3) ? 7'h00 : (k < 5) ? 7'h20 : (k < 7) ? 7'h01 : 7'($urandom);
            x  = pick();
            y  = pick();
            model(o, g3, g7, x, y, er, eil, elat);
            do_op(o, g3, g7, x, y, 1'($urandom_range(0, 1)), r, z, il, lat, ok);
            checks++;
            if (r !== er || z !== (er == 32'h0) || il !== eil) begin
                errors++;
                $display("FAIL rand[%0d] opc=%0d f3=%0d f7=%h a=%h b=%h got res=%h z=%b il=%b exp %h %b %b",
                         n, o, g3, g7, x, y, r, z, il, er, er == 32'h0, eil);
            end
            checks++; if (lat != elat) begin errors++; $display("FAIL rand[%0d]_latency got %0d exp %0d", n, lat, elat); end
            checks++; if (!ok) begin errors++; $display("FAIL rand[%0d]_handshake got bad ready/busy exp ok", n); end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] r; logic z, il; int lat, seen; bit ok;
        do_op(2'd0, 3'd0, 7'h00, 32'd3, 32'd4, 1'b0, r, z, il, lat, ok);
        @(negedge clk);
        opc = 2'd2; f3 = 3'd4; f7 = 7'h01; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b exp 1", busy); end
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset_vals got rdy=%b bsy=%b vld=%b res=%h z=%b il=%b exp 1 0 0 0 1 0",
                     ready, busy, valid, result, zero, illegal);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin @(negedge clk); if (valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid got %0d exp 0", seen); end
        do_op(2'd0, 3'd0, 7'h00, 32'd20, 32'd22, 1'b0, r, z, il, lat, ok);
        checks++; if (r !== 32'd42 || lat != 1) begin errors++; $display("FAIL abort_add_after got res=%h lat=%0d exp 0000002a 1", r, lat); end
    endtask

    task automatic test_width8;
        logic [7:0] ex[2];
        int lat;
        ex[0] = 8'hFE;
        ex[1] = 8'hFD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            opc8 = 2'd2; f7_8 = 7'h01;
            f3_8 = (i == 0) ? 3'd3 : 3'd4;
            a8   = (i == 0) ? 8'hFF : 8'hF9;
            b8   = (i == 0) ? 8'hFF : 8'h02;
            start8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
            lat = 1;
            while (valid8 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
            checks++; if (result8 !== ex[i]) begin errors++; $display("FAIL w8[%0d]_result got %h exp %h", i, result8, ex[i]); end
            checks++; if (lat != 9) begin errors++; $display("FAIL w8[%0d]_latency got %0d exp 9", i, lat); end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0; opc = '0; f3 = '0; f7 = '0; a = '0; b = '0;
        start8 = 1'b0; opc8 = '0; f3_8 = '0; f7_8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_alu;
        test_back_to_back;
        test_mul;
        test_div;
        test_random;
        test_reset_abort;
        test_width8;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered ALU with an integrated multi-cycle multiply/divide engine, the successor to the single-cycle ALU control path. It decodes the ALU opcode class plus func3/func7 itself, executes RV32I integer ops in one cycle and the RV32M MUL/DIV/REM group iteratively, and returns every result through a start/valid handshake. It sits in the multi-cycle datapath between the operand registers and the ALUOut register; the controller FSM stalls on `ready`.

## Interface
- `WIDTH`, 32, datapath width; power of two, at least 8.
- `SHW`, $clog2(WIDTH), shift-amount width; derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `ALU_opc`  in  2  op class: 00 load/store (ADD), 01 branch (SUB), 10 R-type, 11 I-type.
- `func3`  in  3  instruction func3.
- `func7`  in  7  instruction func7; for I-type, only 0x20 on shift-right is used.
- `a`, `b`  in  WIDTH  operands; captured on the accepted `start`.
- `ready`  out  1  idle, can accept `start`.
- `busy`  out  1  multiply/divide in progress; equals ~`ready`.
- `valid`  out  1  one-cycle pulse; `result`/`zero`/`illegal` are new.
- `result`  out  WIDTH  registered result; held until the next `valid`.
- `zero`  out  1  registered, (`result`==0).
- `illegal`  out  1  registered; the accepted op had an undefined func3/func7 combination.

## Operation
- Decode, R-type with func7=0x00: f3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
- Decode, R-type with func7=0x20: f3 0 SUB, 5 SRA.
- Decode, R-type with func7=0x01: f3 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Decode, I-type: same as the func7=0x00 column; f3=5 with func7=0x20 is SRAI; f3=1 or f3=5 with any other func7 is illegal.
- Any other R-type combination is illegal.
- Illegal op: `result`=0, `illegal`=1, single-cycle latency.
- Shifts use `b[SHW-1:0]` only. SLT is signed; SLTU is unsigned; both produce 0 or 1.
- States:
  - IDLE: `ready`=1. On `start` with a simple op → DONE with the result computed. On MUL* → MUL. On DIV/REM* → DIV.
  - MUL: shift-add over |a|, |b| (signedness per op), 2·WIDTH-bit accumulator, one bit per cycle, WIDTH cycles. The final sign fix and the low or high half are selected on the exit to DONE.
  - DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles. Quotient is negated if the operand signs differ (DIV). Remainder takes the dividend's sign (REM).
  - DONE: `valid`=1 for exactly one cycle → IDLE.
- Divide by zero: DIV/DIVU → all ones; REM/REMU → a. Signed overflow (a=most negative, b=−1): DIV → a, REM → 0. Both cases still take full latency.
- `start` while not `ready` is ignored. Operand changes after acceptance have no effect.
- An iteration counter of SHW+1 bits counts down from WIDTH and exits when it reaches 1.

## Timing
- Reset (`rst`=0, async): state IDLE, `ready`=1, `busy`=0, `valid`=0, `result`=0, `zero`=1, `illegal`=0, counter 0. Reset during MUL/DIV aborts the operation; no `valid` is produced.
- Simple and illegal ops: `start` sampled at edge N → `valid`=1 during cycle N+1. `ready`=0 during cycle N+1 only. Back-to-back issue gives one op per 2 cycles.
- MUL/DIV ops: `start` at edge N → `busy` in cycles N+1..N+WIDTH → `valid` in cycle N+WIDTH+1, with `ready`=0 in that cycle. `ready`=1 from N+WIDTH+2.
- `result`, `zero` and `illegal` update only on the edge that raises `valid`. All outputs are registered, with no combinational input-to-output path.

## Test plan
- Reset → all outputs at their reset values. ADD a=5,b=7, ALU_opc=00 → `valid` one cycle later, `result`=12, `zero`=0. SUB (opc 01) a=b=9 → `result`=0, `zero`=1.
- R-type SRA a=0x80000000, b=4 → 0xF8000000. SLTU a=1, b=0xFFFFFFFF → 1. SLT with the same operands → 0. I-type f3=1 with func7=0x20 → `illegal`=1, `result`=0.
- MUL a=0xFFFFFFFF (−1), b=3 → 0xFFFFFFFD. MULH gives 0xFFFFFFFF; MULHU gives 0x00000002. `valid` arrives exactly 33 cycles after `start`; `start` pulses during `busy` are ignored.
- DIV a=−7, b=2 → −3 (0xFFFFFFFD). REM → −1. DIVU 100/7 → 14. REMU → 2.
- DIVU a=0x1234, b=0 → 0xFFFFFFFF. REM with b=0 → 0x1234. DIV a=0x80000000, b=−1 → 0x80000000. REM with the same operands → 0.
- Assert `rst` low at cycle 10 of a DIV → immediate reset values, no `valid`. A fresh ADD after release completes normally. Repeat with WIDTH=8: MULHU 0xFF×0xFF → 0xFE, 9-cycle latency.
